// File: rtl/lfsr_sched_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_sched_pkg
//   Shared definitions for the LFSR counter scheduler.
//   - sched_state_e : FSM state encoding (IDLE, LOAD, RUN, DONE, ABORT)
//   - WDOG_CW       : width of the RUN-phase watchdog cycle counter
//   - rr_next       : round-robin pointer successor (wraps NREQ-1 -> 0)
// -----------------------------------------------------------------------------
package lfsr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } sched_state_e;

  // Watchdog counter width; WDOG must not exceed 2**WDOG_CW.
  localparam int WDOG_CW = 16;

  // Pointer value after granting index idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search begins at ptr_i and wraps from
//   NREQ-1 back to 0; the first asserted request wins.
// Ports
//   req_i  in  NREQ  request vector
//   ptr_i  in  IW    index where the search starts
//   gnt_o  out NREQ  one-hot winner (all zero when no request)
//   idx_o  out IW    encoded winner index (0 when no request)
//   any_o  out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int  cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int o = 0; o < NREQ; o++) begin
      cand = (int'(ptr_i) + o) % NREQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/lfsr_dcnto_sched.sv
// -----------------------------------------------------------------------------
// lfsr_dcnto_sched
//   Time-shares one DW03_lfsr_dcnto LFSR counter between NREQ requesters.
//   A round-robin winner is picked in IDLE, its count_to target is latched,
//   the counter is loaded with SEED (LOAD), enabled until tercnt (RUN), and a
//   one-cycle done pulse is returned to the owner (DONE).
//
//   Optional feature macro: LFSR_SCHED_WDOG_EN
//     When defined, RUN is limited to WDOG cycles; if tercnt has not been
//     seen the FSM goes to ABORT, pulsing err and done[owner] for one cycle.
//     When undefined there is no watchdog and err is constant 0.
//
// Ports
//   clk           in   1           rising-edge clock
//   reset         in   1           asynchronous, active-high
//   req           in   NREQ        level requests, held until done
//   req_count_to  in   NREQ*width  per-requester target, slice i=[i*width +: width]
//   grant         out  NREQ        one-hot owner, LOAD through DONE/ABORT
//   done          out  NREQ        one-cycle completion pulse to the owner
//   busy          out  1           any state other than IDLE
//   err           out  1           one-cycle watchdog abort pulse
//   data          out  width       counter data pin (constant SEED)
//   count_to      out  width       counter count_to pin (latched target)
//   load          out  1           counter load pin, active-low
//   cen           out  1           counter enable pin
//   tercnt        in   1           counter terminal count (count == count_to)
//
//   Observation point for checkers: state_q (sched_state_e).
// -----------------------------------------------------------------------------
module lfsr_dcnto_sched
  import lfsr_sched_pkg::*;
#(
  parameter int               width = 4,
  parameter int               NREQ  = 4,
  parameter logic [width-1:0] SEED  = '0,
  parameter int               WDOG  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*width-1:0] req_count_to,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  err,
  output logic [width-1:0]      data,
  output logic [width-1:0]      count_to,
  output logic                  load,
  output logic                  cen,
  input  logic                  tercnt
);

  localparam int IW = $clog2(NREQ);

  // Elaboration-time parameter sanity.
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("lfsr_dcnto_sched: NREQ must be in 2..16");
  end
  if (WDOG < 1 || WDOG > (1 << WDOG_CW)) begin : g_bad_wdog
    $error("lfsr_dcnto_sched: WDOG out of range for WDOG_CW");
  end

  sched_state_e     state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [width-1:0] count_to_q, count_to_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

`ifdef LFSR_SCHED_WDOG_EN
  localparam logic [WDOG_CW-1:0] WDOG_LAST = WDOG_CW'(WDOG - 1);
  logic [WDOG_CW-1:0] wdog_q, wdog_d;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    count_to_d = count_to_q;
    ptr_d      = ptr_q;
`ifdef LFSR_SCHED_WDOG_EN
    wdog_d     = wdog_q;
`endif

    busy = (state_q != ST_IDLE);
    load = (state_q != ST_LOAD);
    cen  = (state_q == ST_RUN);
    done = '0;
    err  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // req and req_count_to are only looked at here; the target is
        // frozen for the whole transaction.
        if (arb_any) begin
          grant_d    = arb_gnt;
          count_to_d = req_count_to[int'(arb_idx)*width +: width];
          ptr_d      = IW'(rr_next(int'(arb_idx), NREQ));
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
`ifdef LFSR_SCHED_WDOG_EN
        wdog_d  = '0;
`endif
      end
      ST_RUN: begin
        if (tercnt) begin
          state_d = ST_DONE;
`ifdef LFSR_SCHED_WDOG_EN
        end else if (wdog_q == WDOG_LAST) begin
          // WDOG RUN cycles elapsed without tercnt: target unreachable.
          state_d = ST_ABORT;
        end else begin
          wdog_d  = wdog_q + WDOG_CW'(1);
`endif
        end
      end
      ST_DONE: begin
        done    = grant_q;
        grant_d = '0;
        state_d = ST_IDLE;
      end
`ifdef LFSR_SCHED_WDOG_EN
      ST_ABORT: begin
        done    = grant_q;
        err     = 1'b1;
        grant_d = '0;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      count_to_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      count_to_q <= count_to_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef LFSR_SCHED_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  assign grant    = grant_q;
  assign count_to = count_to_q;
  assign data     = SEED;

endmodule

// File: tb/tb_lfsr_dcnto_sched.sv
// -----------------------------------------------------------------------------
// tb_lfsr_dcnto_sched
//   Drives lfsr_dcnto_sched beside a behavioural stand-in for DW03_lfsr_dcnto
//   (4-bit XNOR LFSR, taps 4,3; all-ones is its lock-up state). Expected
//   grant order, latency, enable cycles and pin values come from a reference
//   model built from the scheduling rules. Define LFSR_SCHED_WDOG_EN to also
//   exercise the watchdog abort path.
// -----------------------------------------------------------------------------
module tb_lfsr_dcnto_sched;

  localparam int         W    = 4;
  localparam int         N    = 4;
  localparam logic [W-1:0] SEED = '0;
  localparam int         WDOG = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   rct;
  logic [N-1:0]     grant, done;
  logic             busy, err, load, cen, tercnt;
  logic [W-1:0]     data, count_to;
  logic [W-1:0]     lfsr_q;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_model = 0;
  logic [N-1:0] exp_q[$];

  lfsr_dcnto_sched #(.width(W), .NREQ(N), .SEED(SEED), .WDOG(WDOG)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_count_to (rct),
    .grant        (grant),
    .done         (done),
    .busy         (busy),
    .err          (err),
    .data         (data),
    .count_to     (count_to),
    .load         (load),
    .cen          (cen),
    .tercnt       (tercnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // ---------------- reference LFSR + counter stand-in ----------------
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {s[W-2:0], ~(s[W-1] ^ s[W-2])};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        lfsr_q <= '0;
    else if (!load)   lfsr_q <= data;
    else if (cen)     lfsr_q <= lfsr_step(lfsr_q);
  end
  assign tercnt = (lfsr_q == count_to);

  // RUN cycles needed to reach tgt from SEED (1 when tgt == SEED), -1 if never.
  function automatic int run_len(input logic [W-1:0] tgt);
    logic [W-1:0] s;
    s = SEED;
    for (int k = 1; k <= (1 << W); k++) begin
      if (s == tgt) return k;
      s = lfsr_step(s);
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] target_for(input int k);
    logic [W-1:0] s;
    s = SEED;
    for (int i = 1; i < k; i++) s = lfsr_step(s);
    return s;
  endfunction

  function automatic logic [W-1:0] rand_target();
    logic [W-1:0] t;
    do t = W'($urandom_range(0, (1 << W) - 1)); while (run_len(t) < 0);
    return t;
  endfunction

  // Round-robin rule: first asserted index at or after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int o = 0; o < N; o++)
      if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one full transaction ----------------
  // Entered at a negedge with the DUT in IDLE and req/rct already set up.
  task automatic txn(input bit drop, input bit perturb);
    int w, k, ncen, edges;
    logic [W-1:0] tgt;
    logic [N-1:0] oh;
    logic exp_err;
    check("idle_busy", 32'(busy), 0);
    w       = rr_pick(req, rr_model);
    tgt     = rct[w*W +: W];
    k       = run_len(tgt);
    exp_err = 1'b0;
`ifdef LFSR_SCHED_WDOG_EN
    if (k < 0) begin
      k       = WDOG;
      exp_err = 1'b1;
    end
`endif
    rr_model = (w + 1) % N;
    oh = N'(1) << w;
    exp_q.push_back(oh);

    @(posedge clk); edges = 1; @(negedge clk);
    check("load_grant", 32'(grant), 32'(oh));
    check("load_pin", 32'(load), 0);
    check("load_cen", 32'(cen), 0);
    check("load_busy", 32'(busy), 1);
    check("load_data", 32'(data), 32'(SEED));
    check("load_count_to", 32'(count_to), 32'(tgt));

    ncen = 0;
    while (done == '0 && edges < 60) begin
      @(posedge clk); edges++; @(negedge clk);
      if (cen) ncen++;
      if (perturb && edges == 3)
        for (int i = 0; i < N; i++) rct[i*W +: W] = rand_target();
      check("hold_count_to", 32'(count_to), 32'(tgt));
      check("hold_grant", 32'(grant), 32'(oh));
    end
    check("done_vec", 32'(done), 32'(exp_q.pop_front()));
    check("cen_cycles", 32'(ncen), 32'(k));
    check("latency_edges", 32'(edges), 32'(k + 2));
    check("done_err", 32'(err), 32'(exp_err));
    check("done_cen", 32'(cen), 0);
    if (drop) req[w] = 1'b0;

    @(posedge clk); @(negedge clk);
    check("idle_grant", 32'(grant), 0);
    check("idle_done", 32'(done), 0);
    check("idle_load", 32'(load), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_count_to"}, 32'(count_to), 0);
    check({tag, "_load"}, 32'(load), 1);
    check({tag, "_cen"}, 32'(cen), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] nw;
    reset = 1'b1;
    req   = '0;
    rct   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_noreq");

    // Single requester 0, three RUN cycles.
    rct[0*W +: W] = target_for(3);
    req = 4'b0001;
    txn(1, 0);

    // Target equal to SEED: one RUN cycle.
    rct[2*W +: W] = SEED;
    req = 4'b0100;
    txn(1, 0);

    // All requesters held, equal targets: rotation with wrap.
    for (int i = 0; i < N; i++) rct[i*W +: W] = target_for(2);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) txn(0, 0);
    req = '0;
    @(negedge clk);

    // Targets rewritten during RUN must not disturb the latched one.
    rct[1*W +: W] = target_for(5);
    req = 4'b0010;
    txn(1, 1);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      nw = N'($urandom_range(0, (1 << N) - 1));
      for (int j = 0; j < N; j++)
        if (nw[j] && !req[j]) rct[j*W +: W] = rand_target();
      req = req | nw;
      if (req == '0) begin
        nw = N'(1) << $urandom_range(0, N - 1);
        for (int j = 0; j < N; j++) if (nw[j]) rct[j*W +: W] = rand_target();
        req = nw;
      end
      txn(1, (i % 4) == 0);
    end
    req = '0;
    @(negedge clk);

    // Reset in the middle of RUN.
    rct[1*W +: W] = target_for(12);
    req = 4'b0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_cen", 32'(cen), 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rr_model = 0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    for (int i = 0; i < N; i++) rct[i*W +: W] = rand_target();
    req = 4'b1111;
    txn(1, 0);
    req = '0;
    @(negedge clk);

`ifdef LFSR_SCHED_WDOG_EN
    // Lock-up target: watchdog abort, then the next requester is served.
    rct[1*W +: W] = '1;
    req = 4'b0010;
    txn(1, 0);
    rct[2*W +: W] = target_for(4);
    req = 4'b0100;
    txn(1, 0);
    req = '0;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
